// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed scoreboard display.
//   clog2       : index width for a count, never less than 1
//   NIBBLE_W    : width of one BCD digit on the packed score bus
//   an_drive    : maps a one-hot "lit" vector to the board's anode polarity
package display_pkg;

   localparam int unsigned NIBBLE_W           = 4;
   localparam int unsigned MAX_DIGITS         = 16;
   localparam bit          ACTIVE_LOW_DEFAULT = 1'b1;

   // Bits needed to index n items; a single item still gets one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

   // Active-low boards light an anode with a 0, so invert the lit vector there.
   function automatic logic [MAX_DIGITS-1:0] an_drive(
      input logic [MAX_DIGITS-1:0] onehot,
      input bit                    active_low = ACTIVE_LOW_DEFAULT
   );
      return active_low ? ~onehot : onehot;
   endfunction

endpackage

// File: rtl/display_scan_decoder_if.sv
// Bus between the score logic / segment encoder and the scan decoder.
//   scan_en, manual_sel, digits_in, blank_mask : driven by the master
//   an, sel, digit_out, tick                   : driven by the decoder (slave)
interface display_scan_decoder_if #(
   parameter int unsigned DIGITS = 4
) ();
   import display_pkg::*;

   localparam int unsigned SEL_W = clog2(DIGITS);

   logic                         scan_en;
   logic [SEL_W-1:0]             manual_sel;
   logic [NIBBLE_W*DIGITS-1:0]   digits_in;
   logic [DIGITS-1:0]            blank_mask;
   logic [DIGITS-1:0]            an;
   logic [SEL_W-1:0]             sel;
   logic [NIBBLE_W-1:0]          digit_out;
   logic                         tick;

   modport master (
      output scan_en, manual_sel, digits_in, blank_mask,
      input  an, sel, digit_out, tick
   );

   modport slave (
      input  scan_en, manual_sel, digits_in, blank_mask,
      output an, sel, digit_out, tick
   );

endinterface

// File: rtl/scan_prescaler.sv
// Refresh prescaler: counts DIV cycles per digit slot and flags the guard window.
//   clk, rst   : clock, synchronous active-high reset
//   hold       : manual mode; counter parked at 0, no wrap
//   tick       : registered strobe, high the cycle after a slot wraps
//   wrap_c     : combinational, this edge ends the slot
//   in_guard_c : combinational, the count being loaded on this edge is inside the guard
module scan_prescaler
   import display_pkg::*;
#(
   parameter int unsigned DIV   = 50000,
   parameter int unsigned GUARD = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   output logic tick,
   output logic wrap_c,
   output logic in_guard_c
);

   localparam int unsigned CNT_W = clog2(DIV);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_next;
   logic             hold_q;

   // The first scanning edge after manual mode restarts the slot at 0 so a guard precedes it.
   assign wrap_c = !hold && !hold_q && (cnt_q == CNT_W'(DIV - 1));

   // Next count: parked in manual, restarted after manual, explicit wrap otherwise.
   always_comb begin
      cnt_next = cnt_q + CNT_W'(1);
      if (hold || hold_q || wrap_c) begin
         cnt_next = '0;
      end
   end

   // Guard compare on the next count so the registered anode matches the registered count.
   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard_c = 1'b0;
      end else begin : g_guard
         assign in_guard_c = (cnt_next < CNT_W'(GUARD));
      end
   endgenerate

   // Prescaler state.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         hold_q <= 1'b0;
         tick   <= 1'b0;
      end else begin
         cnt_q  <= cnt_next;
         hold_q <= hold;
         tick   <= wrap_c;
      end
   end

endmodule

// File: rtl/display_scan_decoder.sv
// Time-multiplexed digit scanner for the scoreboard display.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of display_scan_decoder_if
//              in : scan_en, manual_sel, digits_in, blank_mask
//              out: an (one-hot anodes), sel, digit_out, tick -- all registered
module display_scan_decoder
   import display_pkg::*;
#(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned DIV        = 50000,
   parameter int unsigned GUARD      = 2,
   parameter bit          ACTIVE_LOW = ACTIVE_LOW_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   display_scan_decoder_if.slave bus
);

   localparam int unsigned SEL_W = clog2(DIGITS);

   logic                hold;
   logic                tick_q;
   logic                wrap_c;
   logic                in_guard_c;
   logic [SEL_W-1:0]    sel_q;
   logic [SEL_W-1:0]    sel_next;
   logic [DIGITS-1:0]   onehot_next;
   logic [DIGITS-1:0]   lit_next;
   logic [NIBBLE_W-1:0] digit_next;
   logic [NIBBLE_W-1:0] digit_q;
   logic [DIGITS-1:0]   an_q;

   assign hold = ~bus.scan_en;

   scan_prescaler #(
      .DIV   (DIV),
      .GUARD (GUARD)
   ) u_prescaler (
      .clk        (clk),
      .rst        (rst),
      .hold       (hold),
      .tick       (tick_q),
      .wrap_c     (wrap_c),
      .in_guard_c (in_guard_c)
   );

   // Next digit index: manual load when in range, explicit wrap while scanning.
   always_comb begin
      sel_next = sel_q;
      if (hold) begin
         if ({1'b0, bus.manual_sel} < (SEL_W + 1)'(DIGITS)) begin
            sel_next = bus.manual_sel;
         end
      end else if (wrap_c) begin
         sel_next = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
      end
   end

   // One-hot decode and nibble mux off the next index, keeping an/sel/digit_out coherent.
   always_comb begin
      onehot_next = '0;
      digit_next  = '0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (sel_next == SEL_W'(k)) begin
            onehot_next[k] = 1'b1;
            digit_next     = bus.digits_in[k*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   // Manual mode ignores the guard; blanking applies in both modes.
   always_comb begin
      lit_next = '0;
      if (hold || !in_guard_c) begin
         lit_next = onehot_next & ~bus.blank_mask;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q   <= '0;
         digit_q <= '0;
         an_q    <= DIGITS'(an_drive('0, ACTIVE_LOW));
      end else begin
         sel_q   <= sel_next;
         digit_q <= digit_next;
         an_q    <= DIGITS'(an_drive(MAX_DIGITS'(lit_next), ACTIVE_LOW));
      end
   end

   assign bus.sel       = sel_q;
   assign bus.digit_out = digit_q;
   assign bus.an        = an_q;
   assign bus.tick      = tick_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Bench for display_scan_decoder: directed vector table on a 4-digit build,
// hand sequence on a 3-digit build, then random stimulus against a slot model.
module tb_display_scan_decoder;

   logic clk = 1'b0;
   logic rst;
   logic rst_b;

   always #5 clk = ~clk;

   display_scan_decoder_if #(.DIGITS(4)) ifa ();
   display_scan_decoder_if #(.DIGITS(3)) ifb ();

   display_scan_decoder #(.DIGITS(4), .DIV(4), .GUARD(1), .ACTIVE_LOW(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   display_scan_decoder #(.DIGITS(3), .DIV(2), .GUARD(0), .ACTIVE_LOW(1)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ifb.slave)
   );

   typedef struct {
      bit rst;
      bit scan;
      int ms;
      int blank;
      int an;
      int sel;
      int dig;
      int tick;
   } vec_t;

   // Slot-level view: position inside the current slot plus whether a restart is owed.
   typedef struct {
      int sel;
      int pos;
      bit restart;
      int an;
      int digit;
      int tick;
   } mstate_t;

   vec_t    vecs[$];
   mstate_t ma;
   mstate_t mb;
   int      checks = 0;
   int      errors = 0;

   function automatic mstate_t model_step(mstate_t s, int nd, int ndiv, int ng, bit r,
                                          bit scan, int ms, int blank, logic [63:0] dig);
      mstate_t o;
      int      full;
      bit      lit;
      o    = s;
      full = (1 << nd) - 1;
      lit  = 1'b0;
      if (r) begin
         o.sel = 0; o.pos = 0; o.restart = 1'b0; o.tick = 0; o.digit = 0; o.an = full;
         return o;
      end
      o.tick = 0;
      if (!scan) begin
         o.pos     = 0;
         o.restart = 1'b1;
         if (ms < nd) o.sel = ms;
         lit = 1'b1;
      end else begin
         if (s.restart) begin
            o.pos     = 0;
            o.restart = 1'b0;
         end else if (s.pos == ndiv - 1) begin
            o.pos  = 0;
            o.sel  = (s.sel + 1) % nd;
            o.tick = 1;
         end else begin
            o.pos = s.pos + 1;
         end
         lit = (o.pos >= ng);
      end
      if (((blank >> o.sel) & 1) != 0) lit = 1'b0;
      o.digit = int'((dig >> (4 * o.sel)) & 64'hF);
      o.an    = lit ? (full ^ (1 << o.sel)) : full;
      return o;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   // One clock edge: advance both models with the inputs seen at the edge, then settle.
   task automatic step();
      @(posedge clk);
      ma = model_step(ma, 4, 4, 1, rst, ifa.scan_en, int'(ifa.manual_sel),
                      int'(ifa.blank_mask), 64'(ifa.digits_in));
      mb = model_step(mb, 3, 2, 0, rst_b, ifb.scan_en, int'(ifb.manual_sel),
                      int'(ifb.blank_mask), 64'(ifb.digits_in));
      #1;
   endtask

   task automatic add(input int n, input bit r, input bit scan, input int ms, input int blank,
                      input int an, input int sel, input int dig, input int tick);
      vec_t v;
      v.rst = r; v.scan = scan; v.ms = ms; v.blank = blank;
      v.an = an; v.sel = sel; v.dig = dig; v.tick = tick;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic cmp_model_a(input string tag);
      chk({tag, "_a_an"},   int'(ifa.an),        ma.an);
      chk({tag, "_a_sel"},  int'(ifa.sel),       ma.sel);
      chk({tag, "_a_dig"},  int'(ifa.digit_out), ma.digit);
      chk({tag, "_a_tick"}, int'(ifa.tick),      ma.tick);
   endtask

   task automatic cmp_model_b(input string tag);
      chk({tag, "_b_an"},   int'(ifb.an),        mb.an);
      chk({tag, "_b_sel"},  int'(ifb.sel),       mb.sel);
      chk({tag, "_b_dig"},  int'(ifb.digit_out), mb.digit);
      chk({tag, "_b_tick"}, int'(ifb.tick),      mb.tick);
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      rst = 1'b1;
      rst_b = 1'b1;
      ifa.scan_en = 1'b1; ifa.manual_sel = '0; ifa.blank_mask = '0; ifa.digits_in = 16'h4321;
      ifb.scan_en = 1'b1; ifb.manual_sel = '0; ifb.blank_mask = '0; ifb.digits_in = 12'h987;

      // rst scan ms blank | an sel dig tick
      add(3, 1, 1, 0, 0, 4'hF, 0, 0, 0);   // reset
      add(3, 0, 1, 0, 0, 4'hE, 0, 1, 0);   // slot 0 after the reset guard cycle
      add(1, 0, 1, 0, 0, 4'hF, 1, 2, 1);
      add(3, 0, 1, 0, 0, 4'hD, 1, 2, 0);
      add(1, 0, 1, 0, 0, 4'hF, 2, 3, 1);
      add(3, 0, 1, 0, 0, 4'hB, 2, 3, 0);
      add(1, 0, 1, 0, 0, 4'hF, 3, 4, 1);
      add(3, 0, 1, 0, 0, 4'h7, 3, 4, 0);
      add(1, 0, 1, 0, 0, 4'hF, 0, 1, 1);   // wrap back to digit 0
      add(1, 0, 1, 0, 0, 4'hE, 0, 1, 0);
      add(3, 0, 0, 3, 0, 4'h7, 3, 4, 0);   // manual hold on digit 3
      add(1, 0, 0, 1, 0, 4'hD, 1, 2, 0);
      add(1, 0, 1, 0, 0, 4'hF, 1, 2, 0);   // back to scan: guard first, no tick
      add(3, 0, 1, 0, 0, 4'hD, 1, 2, 0);
      add(1, 0, 1, 0, 0, 4'hF, 2, 3, 1);
      add(3, 0, 1, 0, 4, 4'hF, 2, 3, 0);   // digit 2 blanked for its whole slot
      add(1, 0, 1, 0, 4, 4'hF, 3, 4, 1);
      add(1, 0, 1, 0, 4, 4'h7, 3, 4, 0);
      add(2, 0, 1, 0, 0, 4'h7, 3, 4, 0);
      add(1, 0, 1, 0, 0, 4'hF, 0, 1, 1);
      add(3, 0, 1, 0, 0, 4'hE, 0, 1, 0);
      add(1, 0, 1, 0, 0, 4'hF, 1, 2, 1);
      add(3, 0, 1, 0, 0, 4'hD, 1, 2, 0);
      add(1, 0, 1, 0, 0, 4'hF, 2, 3, 1);
      add(2, 0, 1, 0, 0, 4'hB, 2, 3, 0);
      add(1, 1, 1, 0, 0, 4'hF, 0, 0, 0);   // reset mid-slot at sel=2
      add(3, 0, 1, 0, 0, 4'hE, 0, 1, 0);
      add(1, 0, 1, 0, 0, 4'hF, 1, 2, 1);

      foreach (vecs[i]) begin
         rst             = vecs[i].rst;
         ifa.scan_en     = vecs[i].scan;
         ifa.manual_sel  = 2'(vecs[i].ms);
         ifa.blank_mask  = 4'(vecs[i].blank);
         step();
         chk($sformatf("vec%0d_an", i),   int'(ifa.an),        vecs[i].an);
         chk($sformatf("vec%0d_sel", i),  int'(ifa.sel),       vecs[i].sel);
         chk($sformatf("vec%0d_dig", i),  int'(ifa.digit_out), vecs[i].dig);
         chk($sformatf("vec%0d_tick", i), int'(ifa.tick),      vecs[i].tick);
      end

      // 3-digit build: explicit wrap, no index 3, GUARD=0 keeps the anode lit all slot.
      rst_b = 1'b1;
      step();
      chk("b_rst_an", int'(ifb.an), 7);
      chk("b_rst_sel", int'(ifb.sel), 0);
      rst_b = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk($sformatf("b_scan%0d_sel", k),  int'(ifb.sel), (k / 2) % 3);
         chk($sformatf("b_scan%0d_an", k),   int'(ifb.an), 7 ^ (1 << ((k / 2) % 3)));
         chk($sformatf("b_scan%0d_tick", k), int'(ifb.tick), (k % 2 == 0) ? 1 : 0);
         chk($sformatf("b_scan%0d_dig", k),  int'(ifb.digit_out), 7 + (k / 2) % 3);
      end
      ifb.scan_en = 1'b0;
      ifb.manual_sel = 2'd1;
      step();
      chk("b_man_sel", int'(ifb.sel), 1);
      ifb.manual_sel = 2'd3;                // out of range: hold previous index
      for (int k = 0; k < 3; k++) begin
         step();
         chk("b_oor_sel", int'(ifb.sel), 1);
         chk("b_oor_an", int'(ifb.an), 3'b101);
         chk("b_oor_tick", int'(ifb.tick), 0);
      end

      // Random stimulus on both builds against the slot model.
      for (int c = 0; c < 1500; c++) begin
         rst   = ($urandom_range(0, 59) == 0);
         rst_b = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 15) == 0) ifa.scan_en = ~ifa.scan_en;
         if ($urandom_range(0, 15) == 0) ifb.scan_en = ~ifb.scan_en;
         ifa.manual_sel = 2'($urandom_range(0, 3));
         ifb.manual_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) ifa.blank_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) ifb.blank_mask = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) ifa.digits_in = 16'($urandom);
         if ($urandom_range(0, 7) == 0) ifb.digits_in = 12'($urandom);
         step();
         cmp_model_a($sformatf("rnd%0d", c));
         cmp_model_b($sformatf("rnd%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
